cmac_link_supervisor: RTL

Multi-port CMAC link supervisor that generalises single-port alignment supervision to NUM_PORTS independent CMAC instances. Each port runs its own FSM with a programmable RX-datapath reset length, an alignment timeout and a debounce period before link-up is declared. It also enforces a bounded retry count with a sticky FAILED state, provides software restart, and keeps saturating per-port link-loss statistics. It sits beside the CMACs in the rx_clk domain; all stat inputs arrive already synchronised to rx_clk.

---
 rtl/cmac_link_supervisor.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cmac_link_supervisor.sv
// Per-port CMAC bring-up supervisor: RX datapath reset, alignment timeout,
// debounce to link-up, bounded retries with sticky failure, loss statistics.
module cmac_link_supervisor #(
   parameter int          NUM_PORTS       = 2,
   parameter int unsigned RESET_CYCLES    = 50,
   parameter int unsigned ALIGN_CYCLES    = 644531250,
   parameter int unsigned DEBOUNCE_CYCLES = 1024,
   parameter int unsigned MAX_RETRIES     = 8,
   parameter bit          RSFEC           = 1'b1
) (
   input  logic                      rx_clk,
   input  logic                      rx_reset,
   input  logic [NUM_PORTS-1:0]      stat_rx_aligned,
   input  logic [NUM_PORTS-1:0]      restart,
   input  logic                      clear_stats,
   output logic [NUM_PORTS-1:0]      reset_rx_datapath,
   output logic [NUM_PORTS-1:0]      ctl_tx_enable,
   output logic [NUM_PORTS-1:0]      ctl_tx_send_rfi,
   output logic [NUM_PORTS-1:0]      ctl_rx_enable,
   output logic [NUM_PORTS-1:0]      ctl_rsfec_enable,
   output logic [NUM_PORTS-1:0]      link_up,
   output logic [NUM_PORTS-1:0]      link_failed,
   output logic [3*NUM_PORTS-1:0]    port_state,
   output logic [8*NUM_PORTS-1:0]    retry_count,
   output logic [16*NUM_PORTS-1:0]   loss_count
);

   typedef enum logic [2:0] {
      ST_RESET      = 3'd0,
      ST_WAIT_ALIGN = 3'd1,
      ST_DEBOUNCE   = 3'd2,
      ST_UP         = 3'd3,
      ST_FAILED     = 3'd4
   } state_e;

   localparam logic [31:0] RST_LOAD   = RESET_CYCLES;
   localparam logic [31:0] ALIGN_LOAD = ALIGN_CYCLES;
   localparam logic [31:0] DEB_LOAD   = DEBOUNCE_CYCLES;
   localparam logic [7:0]  MAX_RETRY  = 8'(MAX_RETRIES);

   state_e                  state_q [NUM_PORTS];
   state_e                  state_d [NUM_PORTS];
   logic [31:0]             timer_q [NUM_PORTS];
   logic [31:0]             timer_d [NUM_PORTS];
   logic [31:0]             deb_q   [NUM_PORTS];
   logic [31:0]             deb_d   [NUM_PORTS];
   logic [7:0]              retry_q [NUM_PORTS];
   logic [7:0]              retry_d [NUM_PORTS];
   logic [16*NUM_PORTS-1:0] loss_q;
   logic [16*NUM_PORTS-1:0] loss_d;
   logic [NUM_PORTS-1:0]    timeout;

   always_comb begin
      loss_d  = loss_q;
      timeout = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         state_d[i] = state_q[i];
         timer_d[i] = (timer_q[i] == 32'd0) ? 32'd0 : timer_q[i] - 32'd1;
         deb_d[i]   = deb_q[i];
         retry_d[i] = retry_q[i];
         if (restart[i]) begin
            state_d[i] = ST_RESET;
            timer_d[i] = RST_LOAD;
            retry_d[i] = 8'd0;
         end else begin
            case (state_q[i])
               ST_RESET: begin
                  if (timer_q[i] <= 32'd1) begin
                     state_d[i] = ST_WAIT_ALIGN;
                     timer_d[i] = ALIGN_LOAD;
                  end
               end
               ST_WAIT_ALIGN: begin
                  // Advancing on alignment beats a simultaneous timer expiry here.
                  if (stat_rx_aligned[i]) begin
                     if (DEB_LOAD <= 32'd1) begin
                        state_d[i] = ST_UP;
                        retry_d[i] = 8'd0;
                     end else begin
                        state_d[i] = ST_DEBOUNCE;
                        deb_d[i]   = 32'd1;
                     end
                  end else if (timer_q[i] <= 32'd1) begin
                     timeout[i] = 1'b1;
                  end
               end
               ST_DEBOUNCE: begin
                  if (stat_rx_aligned[i] && (deb_q[i] + 32'd1 >= DEB_LOAD)) begin
                     state_d[i] = ST_UP;
                     retry_d[i] = 8'd0;
                  end else if (timer_q[i] <= 32'd1) begin
                     timeout[i] = 1'b1;
                  end else if (!stat_rx_aligned[i]) begin
                     state_d[i] = ST_WAIT_ALIGN;
                  end else begin
                     deb_d[i] = deb_q[i] + 32'd1;
                  end
               end
               ST_UP: begin
                  if (!stat_rx_aligned[i]) begin
                     state_d[i] = ST_RESET;
                     timer_d[i] = RST_LOAD;
                     if (loss_q[16*i +: 16] != 16'hFFFF)
                        loss_d[16*i +: 16] = loss_q[16*i +: 16] + 16'd1;
                  end
               end
               ST_FAILED: ;
               default: state_d[i] = ST_RESET;
            endcase
            if (timeout[i]) begin
               retry_d[i] = (retry_q[i] == 8'hFF) ? 8'hFF : retry_q[i] + 8'd1;
               if ((MAX_RETRY != 8'd0) && (retry_d[i] == MAX_RETRY)) begin
                  state_d[i] = ST_FAILED;
               end else begin
                  state_d[i] = ST_RESET;
                  timer_d[i] = RST_LOAD;
               end
            end
         end
      end
      if (clear_stats)
         loss_d = '0;
   end

   always_ff @(posedge rx_clk) begin
      if (rx_reset) begin
         loss_q <= '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            state_q[i] <= ST_RESET;
            timer_q[i] <= RST_LOAD;
            deb_q[i]   <= 32'd0;
            retry_q[i] <= 8'd0;
         end
      end else begin
         loss_q <= loss_d;
         for (int i = 0; i < NUM_PORTS; i++) begin
            state_q[i] <= state_d[i];
            timer_q[i] <= timer_d[i];
            deb_q[i]   <= deb_d[i];
            retry_q[i] <= retry_d[i];
         end
      end
   end

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port_out
      assign reset_rx_datapath[g]   = (state_q[g] == ST_RESET);
      assign ctl_tx_enable[g]       = (state_q[g] == ST_UP);
      assign ctl_tx_send_rfi[g]     = (state_q[g] != ST_UP);
      assign link_up[g]             = (state_q[g] == ST_UP);
      assign link_failed[g]         = (state_q[g] == ST_FAILED);
      assign port_state[3*g +: 3]   = state_q[g];
      assign retry_count[8*g +: 8]  = retry_q[g];
   end

   assign ctl_rx_enable    = '1;
   assign ctl_rsfec_enable = {NUM_PORTS{RSFEC}};
   assign loss_count       = loss_q;

endmodule
